sound_sequencer: RTL and testbench
==================================

# sound_sequencer

Sound-effect controller for the game's audio path. Four event requesters (ball-ball hit, cushion hit, pocket, win) post single-cycle requests. The block latches them, picks one by fixed priority and steps through that effect's short note list from an internal ROM. Each step drives a 4-bit tone index, 0..11 within one octave, into the downstream tone-to-prescaler decoder, with a gating enable for the tone generator.

## Interface

- TICK_DIV, 500000: clk cycles per duration unit (10 ms at 50 MHz); must be ≥1
- GAP_TICKS, 1: silent duration units inserted after every note; 0 allowed
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- req  in  4  event request pulses; bit 0 ball-ball, 1 cushion, 2 pocket, 3 win
- tone  out  4  tone index to the decoder, registered
- soundEnable  out  1  high while a note sounds, registered
- busy  out  1  high whenever state ≠ IDLE
- playingId  out  2  index of the effect being played, registered

## Operation

- Melody ROM: 4 effects × 8 entries, each entry {tone[3:0], dur[3:0]}. dur=0 marks end of list. Index 8 is also end of list.
  - effect 0: (4,2)
  - effect 1: (0,2)
  - effect 2: (4,3) (9,3) (11,3)
  - effect 3: (0,4) (4,4) (7,4) (0,8)
- pending[3:0]:
  - bit i sets on any cycle req[i]=1.
  - Cleared only when effect i is selected.
  - Set and clear in the same cycle: set wins. A re-request of the playing effect replays it afterwards.
- Selection: highest pending index wins (3 highest).
- States: IDLE, LOAD, PLAY, GAP.
  - IDLE: if pending≠0, then select id, clear pending[id], playingId←id, noteIdx←0, go to LOAD.
  - LOAD: read ROM[playingId][noteIdx].
    - End of list: go to IDLE.
    - Otherwise: tone←entry.tone, soundEnable←1, durCnt←entry.dur, tickCnt←0, go to PLAY.
  - PLAY: tickCnt counts 0..TICK_DIV-1 and wraps. On each wrap, durCnt decrements. On the wrap where durCnt=1:
    - soundEnable←0.
    - If GAP_TICKS>0: go to GAP.
    - Otherwise: noteIdx++, go to LOAD.
  - GAP: counts GAP_TICKS×TICK_DIV cycles, then noteIdx++, go to LOAD.
- soundEnable is 0 in IDLE, LOAD and GAP. tone holds its last value when not sounding.
- Counter widths:
  - tickCnt: $clog2(TICK_DIV+1) bits.
  - durCnt: 4 bits.
  - noteIdx: 4 bits, so 8 is representable.
- Reset at any time, mid-note included: state IDLE, pending=0, and all outputs 0 immediately (asynchronous).

## Timing

- Reset values: tone=0, soundEnable=0, busy=0, playingId=0.
- Request latency: req[i] sampled at edge E0, pending set. Edge E1 goes IDLE→LOAD and busy rises. Edge E2 goes LOAD→PLAY and soundEnable rises. Total: 2 cycles from the sampling edge to soundEnable=1.
- Each note: soundEnable high for exactly dur×TICK_DIV cycles.
- Between consecutive notes: soundEnable low for GAP_TICKS×TICK_DIV+1 cycles (the +1 is the LOAD cycle).
- After the last note, busy falls after the GAP period plus one LOAD cycle.
- A pending effect starts LOAD→PLAY 2 cycles after the IDLE entry (IDLE, LOAD, PLAY).
- Simultaneous requests in one cycle: the higher index plays first; the others remain pending.

## Configuration

- SOUND_PREEMPT_EN defined:
  - In PLAY or GAP, if any pending index is greater than playingId, the next cycle switches to the new effect: id selected, pending cleared, noteIdx←0, state LOAD.
  - soundEnable drops that cycle. The aborted effect is discarded, not resumed.
- SOUND_PREEMPT_EN undefined: the current effect always completes. Requests wait in pending.

## Test plan

Bench settings: TICK_DIV=4, GAP_TICKS=1.

- Reset: assert reset mid-note of effect 3 → all outputs 0 within the same cycle. After release, no sound until a new req.
- Single req[0] → soundEnable rises 2 cycles after sampling. tone=4, high for 8 cycles, then low. busy falls 5 cycles later (4 gap + 1 LOAD).
- req[3] → tone sequence 0,4,7,0 with high times 16,16,16,32 cycles, each followed by 5 low cycles. playingId=3 throughout.
- req[1] and req[2] in the same cycle → effect 2 plays (4,9,11; 12 cycles each), then effect 1 (tone 0, 8 cycles). No req pulses lost.
- Without SOUND_PREEMPT_EN: req[3] during effect 0 → effect 0 completes, then effect 3 plays.
- With SOUND_PREEMPT_EN: req[3] during effect 0 → soundEnable drops next cycle, then tone 0 starts 2 cycles later with playingId=3. Also: req[0] during effect 0 (no preemption, equal index) → effect 0 replays after completion.

Source files
------------

// File: rtl/sound_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sound_sequencer
// Purpose  : Latches four sound-effect requests and plays the highest-priority
//            effect's note list from an internal ROM as a tone index + enable.
//            Optional build macro SOUND_PREEMPT_EN lets a higher effect abort
//            the one currently playing.
// Revision : 1.0  initial release
// ============================================================================
module sound_sequencer #(
  parameter int TICK_DIV  = 500000,
  parameter int GAP_TICKS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] tone,
  output logic       soundEnable,
  output logic       busy,
  output logic [1:0] playingId
);

  localparam int TW = $clog2(TICK_DIV + 1);
  localparam int GW = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
  localparam logic [TW-1:0] C_TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [GW-1:0] C_GAP_LAST  = GW'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t        r_state, w_state;
  logic [3:0]    r_pending, w_pending, w_clr;
  logic [1:0]    r_playing_id, w_playing_id, w_sel;
  logic [3:0]    r_note_idx, w_note_idx;
  logic [3:0]    r_tone, w_tone;
  logic          r_sound_enable, w_sound_enable;
  logic [3:0]    r_dur_cnt, w_dur_cnt;
  logic [TW-1:0] r_tick_cnt, w_tick_cnt;
  logic [GW-1:0] r_gap_cnt, w_gap_cnt;
  logic [7:0]    w_entry;
  logic          w_tick_last;
  logic [3:0]    w_above;

  // Entry = {tone, dur}; dur of zero terminates the list.
  function automatic logic [7:0] rom_read(input logic [1:0] id, input logic [3:0] idx);
    logic [7:0] e;
    e = 8'h00;
    if (!idx[3]) begin
      case ({id, idx[2:0]})
        5'b00_000: e = {4'd4,  4'd2};
        5'b01_000: e = {4'd0,  4'd2};
        5'b10_000: e = {4'd4,  4'd3};
        5'b10_001: e = {4'd9,  4'd3};
        5'b10_010: e = {4'd11, 4'd3};
        5'b11_000: e = {4'd0,  4'd4};
        5'b11_001: e = {4'd4,  4'd4};
        5'b11_010: e = {4'd7,  4'd4};
        5'b11_011: e = {4'd0,  4'd8};
        default:   e = 8'h00;
      endcase
    end
    return e;
  endfunction

  function automatic logic [1:0] pick(input logic [3:0] p);
    if (p[3]) return 2'd3;
    if (p[2]) return 2'd2;
    if (p[1]) return 2'd1;
    return 2'd0;
  endfunction

  assign w_entry     = rom_read(r_playing_id, r_note_idx);
  assign w_tick_last = (r_tick_cnt == C_TICK_LAST);
  assign w_sel       = pick(r_pending);
  assign w_above     = r_pending & (4'b1110 << r_playing_id);
  // A request arriving on the selecting cycle survives the clear.
  assign w_pending   = (r_pending & ~w_clr) | req;

  always_comb begin
    w_state        = r_state;
    w_clr          = 4'b0000;
    w_playing_id   = r_playing_id;
    w_note_idx     = r_note_idx;
    w_tone         = r_tone;
    w_sound_enable = r_sound_enable;
    w_dur_cnt      = r_dur_cnt;
    w_tick_cnt     = r_tick_cnt;
    w_gap_cnt      = r_gap_cnt;

    case (r_state)
      S_IDLE: begin
        if (|r_pending) begin
          w_clr        = 4'b0001 << w_sel;
          w_playing_id = w_sel;
          w_note_idx   = 4'd0;
          w_state      = S_LOAD;
        end
      end
      S_LOAD: begin
        if (r_note_idx[3] || (w_entry[3:0] == 4'd0)) begin
          w_sound_enable = 1'b0;
          w_state        = S_IDLE;
        end else begin
          w_tone         = w_entry[7:4];
          w_sound_enable = 1'b1;
          w_dur_cnt      = w_entry[3:0];
          w_tick_cnt     = '0;
          w_state        = S_PLAY;
        end
      end
      S_PLAY: begin
        w_tick_cnt = w_tick_last ? '0 : r_tick_cnt + TW'(1);
        if (w_tick_last) begin
          w_dur_cnt = r_dur_cnt - 4'd1;
          if (r_dur_cnt == 4'd1) begin
            w_sound_enable = 1'b0;
            if (GAP_TICKS > 0) begin
              w_gap_cnt = '0;
              w_state   = S_GAP;
            end else begin
              w_note_idx = r_note_idx + 4'd1;
              w_state    = S_LOAD;
            end
          end
        end
      end
      S_GAP: begin
        w_tick_cnt = w_tick_last ? '0 : r_tick_cnt + TW'(1);
        if (w_tick_last) begin
          if (r_gap_cnt == C_GAP_LAST) begin
            w_note_idx = r_note_idx + 4'd1;
            w_state    = S_LOAD;
          end else begin
            w_gap_cnt = r_gap_cnt + GW'(1);
          end
        end
      end
      default: w_state = S_IDLE;
    endcase

`ifdef SOUND_PREEMPT_EN
    // A strictly higher pending effect aborts the current one for good.
    if (((r_state == S_PLAY) || (r_state == S_GAP)) && (|w_above)) begin
      w_clr          = 4'b0001 << w_sel;
      w_playing_id   = w_sel;
      w_note_idx     = 4'd0;
      w_sound_enable = 1'b0;
      w_state        = S_LOAD;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_pending      <= 4'b0000;
      r_playing_id   <= 2'd0;
      r_note_idx     <= 4'd0;
      r_tone         <= 4'd0;
      r_sound_enable <= 1'b0;
      r_dur_cnt      <= 4'd0;
      r_tick_cnt     <= '0;
      r_gap_cnt      <= '0;
    end else begin
      r_state        <= w_state;
      r_pending      <= w_pending;
      r_playing_id   <= w_playing_id;
      r_note_idx     <= w_note_idx;
      r_tone         <= w_tone;
      r_sound_enable <= w_sound_enable;
      r_dur_cnt      <= w_dur_cnt;
      r_tick_cnt     <= w_tick_cnt;
      r_gap_cnt      <= w_gap_cnt;
    end
  end

  assign tone        = r_tone;
  assign soundEnable = r_sound_enable;
  assign busy        = (r_state != S_IDLE);
  assign playingId   = r_playing_id;

endmodule
`default_nettype wire

// File: tb/tb_sound_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sound_sequencer
// Purpose  : Self-checking bench for sound_sequencer; expected waveforms are
//            assembled from the effect note tables and the playback timing.
// Revision : 1.0  initial release
// ============================================================================
module tb_sound_sequencer;

  localparam int TD     = 4;
  localparam int GT     = 1;
  localparam int MAXLEN = 1024;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] tone;
  logic       soundEnable;
  logic       busy;
  logic [1:0] playingId;

  typedef struct packed {
    logic       se;
    logic [3:0] tone;
    logic       busy;
    logic [1:0] pid;
  } samp_t;

  samp_t      exp_q[$];
  logic [3:0] sched [MAXLEN];
  int         mel_n [4];
  int         mel_tone [4][4];
  int         mel_dur  [4][4];
  int         checks = 0;
  int         errors = 0;

  sound_sequencer #(.TICK_DIV(TD), .GAP_TICKS(GT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .tone       (tone),
    .soundEnable(soundEnable),
    .busy       (busy),
    .playingId  (playingId)
  );

  always #5 clk = ~clk;

  function automatic void push(input logic se, input int t, input logic b, input int pid);
    samp_t s;
    s.se   = se;
    s.tone = t[3:0];
    s.busy = b;
    s.pid  = pid[1:0];
    exp_q.push_back(s);
  endfunction

  function automatic void push_idle(input int n);
    for (int i = 0; i < n; i++) push(1'b0, 0, 1'b0, 0);
  endfunction

  // One effect starting from the IDLE->LOAD edge: LOAD, then each note
  // followed by its gap and the next LOAD, then the return to IDLE.
  function automatic void append_effect(input int e);
    push(1'b0, 0, 1'b1, e);
    for (int j = 0; j < mel_n[e]; j++) begin
      for (int c = 0; c < mel_dur[e][j] * TD; c++) push(1'b1, mel_tone[e][j], 1'b1, e);
      for (int c = 0; c < GT * TD; c++) push(1'b0, 0, 1'b1, e);
      push(1'b0, 0, 1'b1, e);
    end
    push(1'b0, 0, 1'b0, e);
  endfunction

  function automatic void clear_plan();
    exp_q.delete();
    for (int k = 0; k < MAXLEN; k++) sched[k] = 4'b0000;
  endfunction

  function automatic int pick_play_idx();
    int q[$];
    for (int k = 0; k < exp_q.size(); k++) if (exp_q[k].se) q.push_back(k);
    return q[$urandom_range(0, q.size() - 1)];
  endfunction

  task automatic run_and_compare(input string name);
    int len;
    int n_se, n_tone, n_busy, n_pid;
    int f_se, f_tone, f_busy, f_pid;
    logic       a_se, a_busy;
    logic [3:0] a_tone;
    logic [1:0] a_pid;
    len = exp_q.size();
    n_se = 0; n_tone = 0; n_busy = 0; n_pid = 0;
    f_se = -1; f_tone = -1; f_busy = -1; f_pid = -1;
    a_se = 1'b0; a_busy = 1'b0; a_tone = 4'd0; a_pid = 2'd0;
    for (int k = 0; k < len; k++) begin
      req = sched[k];
      @(posedge clk);
      @(negedge clk);
      if (soundEnable !== exp_q[k].se) begin
        n_se++;
        if (f_se < 0) begin f_se = k; a_se = soundEnable; end
      end
      if (busy !== exp_q[k].busy) begin
        n_busy++;
        if (f_busy < 0) begin f_busy = k; a_busy = busy; end
      end
      if (exp_q[k].se && (tone !== exp_q[k].tone)) begin
        n_tone++;
        if (f_tone < 0) begin f_tone = k; a_tone = tone; end
      end
      if (exp_q[k].busy && (playingId !== exp_q[k].pid)) begin
        n_pid++;
        if (f_pid < 0) begin f_pid = k; a_pid = playingId; end
      end
    end
    req = 4'b0000;
    checks++;
    if (n_se != 0) begin
      errors++;
      $display("FAIL %s soundEnable: %0d bad cycles, first cycle %0d actual %b required %b",
               name, n_se, f_se, a_se, exp_q[f_se].se);
    end
    checks++;
    if (n_busy != 0) begin
      errors++;
      $display("FAIL %s busy: %0d bad cycles, first cycle %0d actual %b required %b",
               name, n_busy, f_busy, a_busy, exp_q[f_busy].busy);
    end
    checks++;
    if (n_tone != 0) begin
      errors++;
      $display("FAIL %s tone: %0d bad cycles, first cycle %0d actual %0d required %0d",
               name, n_tone, f_tone, a_tone, exp_q[f_tone].tone);
    end
    checks++;
    if (n_pid != 0) begin
      errors++;
      $display("FAIL %s playingId: %0d bad cycles, first cycle %0d actual %0d required %0d",
               name, n_pid, f_pid, a_pid, exp_q[f_pid].pid);
    end
  endtask

  task automatic test_reset();
    int noisy;
    checks++;
    if ({tone, soundEnable, busy, playingId} !== 8'h00) begin
      errors++;
      $display("FAIL reset_values actual tone=%0d en=%b busy=%b id=%0d required all 0",
               tone, soundEnable, busy, playingId);
    end
    @(negedge clk);
    reset = 1'b0;
    req = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    req = 4'b0000;
    repeat (30) @(negedge clk);
    checks++;
    if ({soundEnable, tone, playingId} !== {1'b1, 4'd4, 2'd3}) begin
      errors++;
      $display("FAIL midnote_before_reset actual en=%b tone=%0d id=%0d required en=1 tone=4 id=3",
               soundEnable, tone, playingId);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (soundEnable !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_ctrl actual en=%b busy=%b required 0 0", soundEnable, busy);
    end
    checks++;
    if (tone !== 4'd0 || playingId !== 2'd0) begin
      errors++;
      $display("FAIL async_reset_data actual tone=%0d id=%0d required 0 0", tone, playingId);
    end
    @(negedge clk);
    reset = 1'b0;
    noisy = 0;
    repeat (40) begin
      @(negedge clk);
      if (soundEnable !== 1'b0 || busy !== 1'b0) noisy++;
    end
    checks++;
    if (noisy != 0) begin
      errors++;
      $display("FAIL silent_after_reset actual %0d active cycles required 0", noisy);
    end
  endtask

  task automatic test_single();
    for (int e = 0; e < 4; e++) begin
      clear_plan();
      sched[0] = 4'(1 << e);
      push_idle(1);
      append_effect(e);
      push_idle(3);
      run_and_compare($sformatf("single_e%0d", e));
    end
  endtask

  task automatic test_simultaneous();
    clear_plan();
    sched[0] = 4'b0110;
    push_idle(1);
    append_effect(2);
    append_effect(1);
    push_idle(3);
    run_and_compare("simultaneous_1_2");
  endtask

  task automatic test_back_to_back();
    // Second pulse lands on the selecting edge, so the effect replays.
    clear_plan();
    sched[0] = 4'b0001;
    sched[1] = 4'b0001;
    push_idle(1);
    append_effect(0);
    append_effect(0);
    push_idle(3);
    run_and_compare("back_to_back_e0");
  endtask

  task automatic test_random_masks();
    logic [3:0] m;
    int d;
    for (int it = 0; it < 6; it++) begin
      clear_plan();
      m = 4'($urandom_range(1, 15));
      d = $urandom_range(0, 5);
      sched[d] = m;
      push_idle(d + 1);
      for (int e = 3; e >= 0; e--) if (m[e]) append_effect(e);
      push_idle(3);
      run_and_compare($sformatf("random_mask_%0d_m%0h", it, m));
    end
  endtask

  task automatic test_higher_request();
    int lo, hi, p;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        lo = 0; hi = 3;
      end else begin
        lo = $urandom_range(0, 2);
        hi = $urandom_range(lo + 1, 3);
      end
      clear_plan();
      sched[0] = 4'(1 << lo);
      push_idle(1);
      append_effect(lo);
      p = pick_play_idx();
      sched[p] = 4'(1 << hi);
`ifdef SOUND_PREEMPT_EN
      while (exp_q.size() > p + 1) void'(exp_q.pop_back());
`endif
      append_effect(hi);
      push_idle(3);
      run_and_compare($sformatf("higher_req_%0d_lo%0d_hi%0d_at%0d", it, lo, hi, p));
    end
  endtask

  task automatic test_rerequest();
    int e, p;
    for (int it = 0; it < 3; it++) begin
      e = (it == 0) ? 0 : $urandom_range(0, 3);
      clear_plan();
      sched[0] = 4'(1 << e);
      push_idle(1);
      append_effect(e);
      p = pick_play_idx();
      sched[p] = 4'(1 << e);
      append_effect(e);
      push_idle(3);
      run_and_compare($sformatf("rerequest_%0d_e%0d_at%0d", it, e, p));
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    mel_n    = '{1, 1, 3, 4};
    mel_tone = '{'{4, 0, 0, 0}, '{0, 0, 0, 0}, '{4, 9, 11, 0}, '{0, 4, 7, 0}};
    mel_dur  = '{'{2, 0, 0, 0}, '{2, 0, 0, 0}, '{3, 3, 3, 0},  '{4, 4, 4, 8}};
    repeat (2) @(negedge clk);
    test_reset();
    test_single();
    test_simultaneous();
    test_back_to_back();
    test_random_masks();
    test_higher_request();
    test_rerequest();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
